// File: rtl/reflet_mem_bridge_pkg.sv
// Shared types for the Reflet memory bridge: FSM state encoding and timer sizing.
package reflet_mem_bridge_pkg;

  typedef enum logic [1:0] {
    MBR_IDLE  = 2'd0,
    MBR_READ  = 2'd1,
    MBR_WRITE = 2'd2
  } mbr_state_t;

  // Counter width able to hold 0..limit; a disabled timer still gets one bit.
  function automatic int timer_width(input int limit);
    return (limit > 0) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/reflet_mem_bridge_if.sv
// CPU RAM port plus request/acknowledge bus seen by the bridge.
// master = bridge side, slave = CPU/memory environment side.
interface reflet_mem_bridge_if #(
  parameter int wordsize = 16
);
  logic [wordsize-1:0] cpu_addr;
  logic [wordsize-1:0] cpu_data_out;
  logic                cpu_write_en;
  logic [wordsize-1:0] cpu_data_in;
  logic                cpu_enable;
  logic                mem_req;
  logic [wordsize-1:0] mem_addr;
  logic [wordsize-1:0] mem_data_out;
  logic                mem_write_en;
  logic [wordsize-1:0] mem_data_in;
  logic                mem_ack;
  logic                bus_error;

  modport master (
    input  cpu_addr, cpu_data_out, cpu_write_en, mem_data_in, mem_ack,
    output cpu_data_in, cpu_enable, mem_req, mem_addr, mem_data_out, mem_write_en, bus_error
  );

  modport slave (
    output cpu_addr, cpu_data_out, cpu_write_en, mem_data_in, mem_ack,
    input  cpu_data_in, cpu_enable, mem_req, mem_addr, mem_data_out, mem_write_en, bus_error
  );
endinterface

// File: rtl/reflet_mem_bridge_timer.sv
// Saturating bus-wait timer; expired pulses in the timeout-th enabled cycle after clear.
// Constant 0 when timeout is 0, so the bridge then waits forever for an ack.
module reflet_bus_timer
  import reflet_mem_bridge_pkg::*;
#(
  parameter int timeout = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (timeout == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int W = timer_width(timeout);
      localparam logic [W-1:0] LIMIT = W'(timeout);
      localparam logic [W-1:0] LAST  = W'(timeout - 1);

      logic [W-1:0] count;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          count <= '0;
        end else if (clear) begin
          count <= '0;
        end else if (enable && count != LIMIT) begin
          count <= count + 1'b1;
        end
      end

      // Count holds the number of completed wait cycles, so the current cycle is the last one here.
      assign expired = enable && (count == LAST);
    end
  endgenerate

endmodule

// File: rtl/reflet_mem_bridge.sv
// Bridges the Reflet fixed-latency RAM port onto a req/ack bus, stalling the CPU via cpu_enable.
// Hits cost 0 cycles; a miss costs 2 cycles minimum; ack or timeout ends the access.
module reflet_mem_bridge
  import reflet_mem_bridge_pkg::*;
#(
  parameter int wordsize = 16,
  parameter int timeout  = 255
) (
  input logic               clk,
  input logic               reset,
  reflet_mem_bridge_if.master bus
);

  mbr_state_t          state;
  logic                hold_valid;
  logic [wordsize-1:0] hold_addr;
  logic [wordsize-1:0] hold_data;
  logic                mem_req;
  logic [wordsize-1:0] mem_addr;
  logic [wordsize-1:0] mem_data_out;
  logic                mem_write_en;
  logic                bus_error;

  logic addr_match;
  logic hit;
  logic idle;
  logic expired;

  assign addr_match = hold_valid && (bus.cpu_addr == hold_addr);
  // A write only hits when it would not change the held word.
  assign hit  = addr_match && (!bus.cpu_write_en || (bus.cpu_data_out == hold_data));
  assign idle = (state == MBR_IDLE);

  reflet_bus_timer #(
    .timeout(timeout)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (idle && !hit),
    .enable (!idle),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= MBR_IDLE;
      hold_valid   <= 1'b0;
      hold_addr    <= '0;
      hold_data    <= '0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      mem_data_out <= '0;
      mem_write_en <= 1'b0;
      bus_error    <= 1'b0;
    end else begin
      case (state)
        MBR_IDLE: begin
          if (!hit) begin
            mem_addr     <= bus.cpu_addr;
            mem_data_out <= bus.cpu_write_en ? bus.cpu_data_out : '0;
            mem_write_en <= bus.cpu_write_en;
            mem_req      <= 1'b1;
            hold_valid   <= 1'b0;
            state        <= bus.cpu_write_en ? MBR_WRITE : MBR_READ;
          end
        end
        MBR_READ, MBR_WRITE: begin
          // Ack takes priority over a simultaneous expiry.
          if (bus.mem_ack) begin
            hold_addr  <= mem_addr;
            hold_data  <= (state == MBR_READ) ? bus.mem_data_in : mem_data_out;
            hold_valid <= 1'b1;
            mem_req    <= 1'b0;
            state      <= MBR_IDLE;
          end else if (expired) begin
            hold_addr  <= mem_addr;
            hold_data  <= (state == MBR_READ) ? '0 : mem_data_out;
            hold_valid <= 1'b1;
            mem_req    <= 1'b0;
            bus_error  <= 1'b1;
            state      <= MBR_IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= MBR_IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_enable   = hit && idle;
  assign bus.cpu_data_in  = hold_data;
  assign bus.mem_req      = mem_req;
  assign bus.mem_addr     = mem_addr;
  assign bus.mem_data_out = mem_data_out;
  assign bus.mem_write_en = mem_write_en;
  assign bus.bus_error    = bus_error;

endmodule

// File: tb/tb_reflet_mem_bridge.sv
// Directed bench for reflet_mem_bridge: one instance with the default timeout, one with timeout 4.
module tb_reflet_mem_bridge;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  reflet_mem_bridge_if #(.wordsize(16)) bus ();
  reflet_mem_bridge_if #(.wordsize(16)) bus4 ();

  reflet_mem_bridge #(.wordsize(16), .timeout(255)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  reflet_mem_bridge #(.wordsize(16), .timeout(4)) dut4 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus4)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.cpu_addr = 16'h0010; bus.cpu_data_out = 16'h0; bus.cpu_write_en = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_data_in = 16'h1234;
    bus4.cpu_addr = 16'h0000; bus4.cpu_data_out = 16'h0; bus4.cpu_write_en = 1'b0;
    bus4.mem_ack = 1'b1; bus4.mem_data_in = 16'h0000;
    #12;
    n_checks++; if (bus.cpu_enable !== 1'b0) begin n_fail++; $display("FAIL reset_enable: got %b want 0", bus.cpu_enable); end
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", bus.mem_req); end
    n_checks++; if (bus.cpu_data_in !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0000", bus.cpu_data_in); end
    n_checks++; if (bus.mem_addr !== 16'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0000", bus.mem_addr); end
    n_checks++; if (bus.bus_error !== 1'b0) begin n_fail++; $display("FAIL reset_bus_error: got %b want 0", bus.bus_error); end
    n_checks++; if (bus4.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req4: got %b want 0", bus4.mem_req); end
    @(negedge clk);
    reset = 1'b1;
    bus.mem_ack = 1'b1;
    step();
    n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b want 1", bus.mem_req); end
    n_checks++; if (bus.cpu_enable !== 1'b0) begin n_fail++; $display("FAIL first_stall: got %b want 0", bus.cpu_enable); end
    n_checks++; if (bus.mem_addr !== 16'h0010) begin n_fail++; $display("FAIL first_addr: got %h want 0010", bus.mem_addr); end
    n_checks++; if (bus.mem_write_en !== 1'b0) begin n_fail++; $display("FAIL first_dir: got %b want 0", bus.mem_write_en); end
    step();
    n_checks++; if (bus.cpu_enable !== 1'b1) begin n_fail++; $display("FAIL first_enable: got %b want 1", bus.cpu_enable); end
    n_checks++; if (bus.cpu_data_in !== 16'h1234) begin n_fail++; $display("FAIL first_data: got %h want 1234", bus.cpu_data_in); end
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL first_req_drop: got %b want 0", bus.mem_req); end
    n_checks++; if (bus4.cpu_enable !== 1'b1) begin n_fail++; $display("FAIL first_enable4: got %b want 1", bus4.cpu_enable); end
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_variable_latency();
    int stall = 0;
    int extra = 0;
    bus.cpu_addr = 16'h0030;
    #1;
    if (!bus.cpu_enable) stall++;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (!bus.cpu_enable) stall++;
      n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL varlat_req_%0d: got %b want 1", k, bus.mem_req); end
      if (k == 5) begin
        bus.mem_ack = 1'b1;
        bus.mem_data_in = 16'hBEEF;
      end
    end
    step();
    bus.mem_ack = 1'b0;
    n_checks++; if (stall != 6) begin n_fail++; $display("FAIL varlat_stall: got %0d cycles want 6", stall); end
    n_checks++; if (bus.cpu_enable !== 1'b1) begin n_fail++; $display("FAIL varlat_enable: got %b want 1", bus.cpu_enable); end
    n_checks++; if (bus.cpu_data_in !== 16'hBEEF) begin n_fail++; $display("FAIL varlat_data: got %h want beef", bus.cpu_data_in); end
    for (int k = 0; k < 3; k++) begin
      step();
      if (bus.mem_req) extra++;
    end
    n_checks++; if (extra != 0) begin n_fail++; $display("FAIL varlat_no_reissue: got %0d req cycles want 0", extra); end
    n_checks++; if (bus.cpu_enable !== 1'b1) begin n_fail++; $display("FAIL varlat_hold_enable: got %b want 1", bus.cpu_enable); end
  endtask

  task automatic test_write_through();
    int writes = 0;
    bus.cpu_addr = 16'h0020; bus.cpu_data_out = 16'hA5A5; bus.cpu_write_en = 1'b1;
    #1;
    n_checks++; if (bus.cpu_enable !== 1'b0) begin n_fail++; $display("FAIL wr_miss: got %b want 0", bus.cpu_enable); end
    step();
    if (bus.mem_req && bus.mem_write_en) writes++;
    n_checks++; if (bus.mem_write_en !== 1'b1) begin n_fail++; $display("FAIL wr_dir: got %b want 1", bus.mem_write_en); end
    n_checks++; if (bus.mem_data_out !== 16'hA5A5) begin n_fail++; $display("FAIL wr_data_out: got %h want a5a5", bus.mem_data_out); end
    n_checks++; if (bus.mem_addr !== 16'h0020) begin n_fail++; $display("FAIL wr_addr: got %h want 0020", bus.mem_addr); end
    bus.mem_ack = 1'b1;
    bus.mem_data_in = 16'hDEAD;
    step();
    bus.mem_ack = 1'b0;
    n_checks++; if (bus.cpu_enable !== 1'b1) begin n_fail++; $display("FAIL wr_done: got %b want 1", bus.cpu_enable); end
    bus.cpu_write_en = 1'b0;
    #1;
    n_checks++; if (bus.cpu_enable !== 1'b1) begin n_fail++; $display("FAIL wt_read_hit: got %b want 1", bus.cpu_enable); end
    n_checks++; if (bus.cpu_data_in !== 16'hA5A5) begin n_fail++; $display("FAIL wt_read_data: got %h want a5a5", bus.cpu_data_in); end
    for (int k = 0; k < 3; k++) begin
      step();
      if (bus.mem_req) writes++;
    end
    n_checks++; if (writes != 1) begin n_fail++; $display("FAIL wt_bus_count: got %0d bus cycles want 1", writes); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] addrs [0:2];
    logic [15:0] datas [0:2];
    addrs[0] = 16'h0100; addrs[1] = 16'h0102; addrs[2] = 16'h0104;
    datas[0] = 16'h1111; datas[1] = 16'h2222; datas[2] = 16'h3333;
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      bus.cpu_addr = addrs[i];
      bus.mem_data_in = datas[i];
      #1;
      n_checks++; if (bus.cpu_enable !== 1'b0) begin n_fail++; $display("FAIL b2b_miss_%0d: got %b want 0", i, bus.cpu_enable); end
      step();
      n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== addrs[i]) begin
        n_fail++; $display("FAIL b2b_req_%0d: got req %b addr %h want 1 %h", i, bus.mem_req, bus.mem_addr, addrs[i]);
      end
      step();
      n_checks++; if (bus.cpu_enable !== 1'b1 || bus.cpu_data_in !== datas[i]) begin
        n_fail++; $display("FAIL b2b_done_%0d: got en %b data %h want 1 %h", i, bus.cpu_enable, bus.cpu_data_in, datas[i]);
      end
    end
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_ack_at_expiry();
    bus4.mem_ack = 1'b0;
    bus4.cpu_addr = 16'h0060;
    bus4.mem_data_in = 16'h5A5A;
    #1;
    n_checks++; if (bus4.cpu_enable !== 1'b0) begin n_fail++; $display("FAIL exp_miss: got %b want 0", bus4.cpu_enable); end
    for (int k = 1; k <= 4; k++) begin
      step();
      n_checks++; if (bus4.mem_req !== 1'b1) begin n_fail++; $display("FAIL exp_req_%0d: got %b want 1", k, bus4.mem_req); end
      if (k == 4) bus4.mem_ack = 1'b1;
    end
    step();
    bus4.mem_ack = 1'b0;
    n_checks++; if (bus4.cpu_enable !== 1'b1) begin n_fail++; $display("FAIL exp_enable: got %b want 1", bus4.cpu_enable); end
    n_checks++; if (bus4.cpu_data_in !== 16'h5A5A) begin n_fail++; $display("FAIL exp_data: got %h want 5a5a", bus4.cpu_data_in); end
    n_checks++; if (bus4.bus_error !== 1'b0) begin n_fail++; $display("FAIL exp_bus_error: got %b want 0", bus4.bus_error); end
  endtask

  task automatic test_timeout();
    int  reqs = 0;
    bit  done = 1'b0;
    bus4.cpu_addr = 16'h0070;
    bus4.mem_data_in = 16'hFFFF;
    for (int k = 0; k < 12 && !done; k++) begin
      step();
      if (bus4.cpu_enable) done = 1'b1;
      else if (bus4.mem_req) reqs++;
    end
    n_checks++; if (!done) begin n_fail++; $display("FAIL to_wait: enable never rose within 12 cycles"); end
    n_checks++; if (reqs != 4) begin n_fail++; $display("FAIL to_req_cycles: got %0d want 4", reqs); end
    n_checks++; if (bus4.mem_req !== 1'b0) begin n_fail++; $display("FAIL to_req_drop: got %b want 0", bus4.mem_req); end
    n_checks++; if (bus4.cpu_data_in !== 16'h0) begin n_fail++; $display("FAIL to_data: got %h want 0000", bus4.cpu_data_in); end
    n_checks++; if (bus4.bus_error !== 1'b1) begin n_fail++; $display("FAIL to_bus_error: got %b want 1", bus4.bus_error); end
    bus4.cpu_addr = 16'h0072;
    bus4.mem_data_in = 16'h0777;
    bus4.mem_ack = 1'b1;
    step();
    step();
    bus4.mem_ack = 1'b0;
    n_checks++; if (bus4.cpu_enable !== 1'b1 || bus4.cpu_data_in !== 16'h0777) begin
      n_fail++; $display("FAIL to_next_access: got en %b data %h want 1 0777", bus4.cpu_enable, bus4.cpu_data_in);
    end
    n_checks++; if (bus4.bus_error !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b want 1", bus4.bus_error); end
  endtask

  task automatic test_reset_mid();
    bus.cpu_addr = 16'h0080;
    step();
    n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL mid_req: got %b want 1", bus.mem_req); end
    #1;
    reset = 1'b0;
    #1;
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL mid_req_async: got %b want 0", bus.mem_req); end
    n_checks++; if (bus.cpu_enable !== 1'b0) begin n_fail++; $display("FAIL mid_enable: got %b want 0", bus.cpu_enable); end
    n_checks++; if (bus.cpu_data_in !== 16'h0) begin n_fail++; $display("FAIL mid_data: got %h want 0000", bus.cpu_data_in); end
    n_checks++; if (bus.mem_addr !== 16'h0) begin n_fail++; $display("FAIL mid_mem_addr: got %h want 0000", bus.mem_addr); end
    n_checks++; if (bus4.bus_error !== 1'b0) begin n_fail++; $display("FAIL mid_bus_error: got %b want 0", bus4.bus_error); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_variable_latency();
    test_write_through();
    test_back_to_back();
    test_ack_at_expiry();
    test_timeout();
    test_reset_mid();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
